// File: rtl/mips_multicycle_ctl_pkg.sv
// Shared state, opcode and control-field encodings
// for the multicycle MIPS controller.
package mips_multicycle_ctl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_RT    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
  } ctl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctl_outdec.sv
// Moore control-word decoder: state -> datapath
// selects and write enables, gated by reset.
module mips_ctl_outdec
  import mips_multicycle_ctl_pkg::*;
(
  input  state_t     state,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_rdy,
  output ctl_t       ctl,
  output logic       pc_en,
  output logic       illegal_op
);

  logic pcwrite;
  logic branch;

  // Per-state control word; everything defaults to 0
  always_comb begin
    ctl        = '0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          ctl.alusrcb = ALUSRCB_FOUR;
          ctl.irwrite = mem_rdy;
          pcwrite     = mem_rdy;
        end
        S_DECODE: begin
          ctl.alusrcb = ALUSRCB_IMMSH;
          illegal_op  = !op_legal(opcode);
        end
        S_MEMADR, S_ADDIEX: begin
          ctl.alusrca = 1'b1;
          ctl.alusrcb = ALUSRCB_IMM;
        end
        S_MEMRD: ctl.iord = 1'b1;
        S_MEMWB: begin
          ctl.memtoreg = 1'b1;
          ctl.regwrite = 1'b1;
        end
        S_MEMWR: begin
          ctl.iord     = 1'b1;
          ctl.memwrite = 1'b1;
        end
        S_EXEC: begin
          ctl.alusrca = 1'b1;
          ctl.aluop   = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          ctl.regdst   = 1'b1;
          ctl.regwrite = 1'b1;
        end
        S_BRANCH: begin
          ctl.alusrca = 1'b1;
          ctl.aluop   = ALUOP_SUB;
          ctl.pcsrc   = PCSRC_ALUOUT;
          branch      = 1'b1;
        end
        S_ADDIWB: ctl.regwrite = 1'b1;
        S_JUMP: begin
          ctl.pcsrc = PCSRC_JUMP;
          pcwrite   = 1'b1;
        end
        default: ;
      endcase
    end
    pc_en = pcwrite | (branch & zero);
  end

endmodule

// File: rtl/mips_multicycle_ctl.sv
// Multicycle MIPS control FSM: state register,
// next-state logic and control-word decode.
module mips_multicycle_ctl
  import mips_multicycle_ctl_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;
  ctl_t   ctl;
  logic   mem_rdy;

  assign mem_rdy = mem_ready | ~MEM_HANDSHAKE;

  // State register, synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state sequencing by opcode and memory handshake
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  mips_ctl_outdec u_outdec (
    .state      (state_q),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_rdy    (mem_rdy),
    .ctl        (ctl),
    .pc_en      (pc_en),
    .illegal_op (illegal_op)
  );

  assign iord     = ctl.iord;
  assign irwrite  = ctl.irwrite;
  assign memwrite = ctl.memwrite;
  assign regwrite = ctl.regwrite;
  assign regdst   = ctl.regdst;
  assign memtoreg = ctl.memtoreg;
  assign alusrca  = ctl.alusrca;
  assign alusrcb  = ctl.alusrcb;
  assign aluop    = ctl.aluop;
  assign pcsrc    = ctl.pcsrc;
  assign state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctl.sv
// Directed per-cycle bench for the multicycle
// MIPS controller: state and control word.
module tb_mips_multicycle_ctl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, irwrite, memwrite;
  logic       regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       illegal_op;
  logic [3:0] state;
  logic [14:0] cw;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctl dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .iord       (iord),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .pcsrc      (pcsrc),
    .illegal_op (illegal_op),
    .state      (state)
  );

  assign cw = {pc_en, iord, irwrite, memwrite,
               regwrite, regdst, memtoreg, alusrca,
               alusrcb, aluop, pcsrc, illegal_op};

  // {pc_en,iord,irwrite,memwrite,regwrite,regdst,
  //  memtoreg,alusrca,alusrcb,aluop,pcsrc,illegal}
  localparam logic [14:0] W_ZERO  = 15'b0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [14:0] W_FETCH = 15'b1_0_1_0_0_0_0_0_01_00_00_0;
  localparam logic [14:0] W_FSTL  = 15'b0_0_0_0_0_0_0_0_01_00_00_0;
  localparam logic [14:0] W_DEC   = 15'b0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [14:0] W_ILL   = 15'b0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [14:0] W_MADR  = 15'b0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [14:0] W_MRD   = 15'b0_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [14:0] W_MWB   = 15'b0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [14:0] W_MWR   = 15'b0_1_0_1_0_0_0_0_00_00_00_0;
  localparam logic [14:0] W_EXEC  = 15'b0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [14:0] W_ALUWB = 15'b0_0_0_0_1_1_0_0_00_00_00_0;
  localparam logic [14:0] W_BRT   = 15'b1_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [14:0] W_BRN   = 15'b0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [14:0] W_ADWB  = 15'b0_0_0_0_1_0_0_0_00_00_00_0;
  localparam logic [14:0] W_JUMP  = 15'b1_0_0_0_0_0_0_0_00_00_10_0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, check, advance
  task automatic cyc(input logic r,
                     input logic [5:0] op,
                     input logic z,
                     input logic rdy,
                     input logic [3:0] es,
                     input logic [14:0] ew,
                     input string tag);
    reset = r;
    opcode = op;
    zero = z;
    mem_ready = rdy;
    #1;
    check({tag, ".st"}, 32'(state), 32'(es));
    check({tag, ".cw"}, 32'(cw), 32'(ew));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    opcode = 6'h00;
    zero = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 6'h00, 0, 1, 4'd0, W_ZERO, "rst1");
    cyc(1, 6'h00, 0, 1, 4'd0, W_ZERO, "rst2");

    cyc(0, 6'h23, 0, 1, 4'd0, W_FETCH, "lw_f");
    cyc(0, 6'h23, 0, 1, 4'd1, W_DEC, "lw_d");
    cyc(0, 6'h23, 0, 1, 4'd2, W_MADR, "lw_a");
    cyc(0, 6'h23, 0, 1, 4'd3, W_MRD, "lw_r");
    cyc(0, 6'h23, 0, 1, 4'd4, W_MWB, "lw_wb");

    cyc(0, 6'h2B, 0, 1, 4'd0, W_FETCH, "sw_f");
    cyc(0, 6'h2B, 0, 1, 4'd1, W_DEC, "sw_d");
    cyc(0, 6'h2B, 0, 1, 4'd2, W_MADR, "sw_a");
    cyc(0, 6'h2B, 0, 0, 4'd5, W_MWR, "sw_w0");
    cyc(0, 6'h2B, 0, 0, 4'd5, W_MWR, "sw_w1");
    cyc(0, 6'h2B, 0, 0, 4'd5, W_MWR, "sw_w2");
    cyc(0, 6'h2B, 0, 1, 4'd5, W_MWR, "sw_w3");

    cyc(0, 6'h04, 1, 1, 4'd0, W_FETCH, "bt_f");
    cyc(0, 6'h04, 1, 1, 4'd1, W_DEC, "bt_d");
    cyc(0, 6'h04, 1, 1, 4'd8, W_BRT, "bt_b");
    cyc(0, 6'h04, 0, 1, 4'd0, W_FETCH, "bn_f");
    cyc(0, 6'h04, 0, 1, 4'd1, W_DEC, "bn_d");
    cyc(0, 6'h04, 0, 1, 4'd8, W_BRN, "bn_b");

    cyc(0, 6'h00, 0, 1, 4'd0, W_FETCH, "r_f");
    cyc(0, 6'h00, 0, 1, 4'd1, W_DEC, "r_d");
    cyc(0, 6'h00, 0, 1, 4'd6, W_EXEC, "r_ex");
    cyc(0, 6'h00, 0, 1, 4'd7, W_ALUWB, "r_wb");
    cyc(0, 6'h08, 0, 1, 4'd0, W_FETCH, "ai_f");
    cyc(0, 6'h08, 0, 1, 4'd1, W_DEC, "ai_d");
    cyc(0, 6'h08, 0, 1, 4'd9, W_MADR, "ai_ex");
    cyc(0, 6'h08, 0, 1, 4'd10, W_ADWB, "ai_wb");

    cyc(0, 6'h02, 0, 1, 4'd0, W_FETCH, "j_f");
    cyc(0, 6'h02, 0, 1, 4'd1, W_DEC, "j_d");
    cyc(0, 6'h02, 0, 1, 4'd11, W_JUMP, "j_j");

    cyc(0, 6'h3F, 0, 1, 4'd0, W_FETCH, "il_f");
    cyc(0, 6'h3F, 0, 1, 4'd1, W_ILL, "il_d");

    cyc(0, 6'h23, 0, 0, 4'd0, W_FSTL, "fs_0");
    cyc(0, 6'h23, 0, 1, 4'd0, W_FETCH, "fs_1");
    cyc(0, 6'h23, 0, 1, 4'd1, W_DEC, "lr_d");
    cyc(0, 6'h23, 0, 1, 4'd2, W_MADR, "lr_a");
    cyc(0, 6'h23, 0, 0, 4'd3, W_MRD, "lr_r0");
    cyc(0, 6'h23, 0, 1, 4'd3, W_MRD, "lr_r1");
    cyc(0, 6'h23, 0, 1, 4'd4, W_MWB, "lr_wb");

    cyc(0, 6'h2B, 0, 1, 4'd0, W_FETCH, "rw_f");
    cyc(0, 6'h2B, 0, 1, 4'd1, W_DEC, "rw_d");
    cyc(0, 6'h2B, 0, 1, 4'd2, W_MADR, "rw_a");
    cyc(1, 6'h2B, 0, 0, 4'd5, W_ZERO, "rw_rst");
    cyc(0, 6'h2B, 0, 1, 4'd0, W_FETCH, "rw_post");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
